serial_encoder: RTL and testbench
=================================

SERIAL_ENCODER -- requirements
Module: serial_encoder

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 20, the width of the input bit vector.
REQ-002 SHALL have parameter IDX_WIDTH, default 5, the width of an emitted index (ceil(log2(BIT_WIDTH))).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port input_bits, input, BIT_WIDTH, the vector to encode.
REQ-006 SHALL have port in_valid, input, 1, input_bits valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a vector.
REQ-008 SHALL have port out_index, output, IDX_WIDTH, binary index of the current set bit.
REQ-009 SHALL have port out_valid, output, 1, out_index valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts out_index.
REQ-011 SHALL have port out_last, output, 1, the current beat is the final set bit of the vector.
REQ-012 SHALL have port zero_seen, output, 1, one-cycle pulse when an all-zero vector is accepted.

Function
REQ-013 SHALL implement two states: IDLE and EMIT.
REQ-014 SHALL drive in_ready=1 in IDLE and in_ready=0 in EMIT.
REQ-015 SHALL accept the input when in_valid && in_ready at a rising edge and capture input_bits into a pending register.
REQ-016 SHALL, on accepting a non-zero vector, enter EMIT with out_valid=1 in the next cycle (latency 1 cycle).
REQ-017 SHALL, on accepting an all-zero vector, stay in IDLE, emit no beat and assert zero_seen for exactly the next cycle.
REQ-018 SHALL drive out_index with the index of the lowest set bit of the pending register (LSB-first order).
REQ-019 SHALL drive out_last=1 when exactly one bit remains set in the pending register, else 0.
REQ-020 SHALL, on out_valid && out_ready, clear that lowest set bit; on the out_last beat, return to IDLE with out_valid=0 in the next cycle.
REQ-021 SHALL hold out_index, out_last and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL emit one beat per cycle while out_ready stays high; a vector with k set bits completes in k cycles after the first beat.
REQ-023 SHALL ignore in_valid and input_bits during EMIT; there is no overlap between vectors.
REQ-024 SHALL handle bit BIT_WIDTH-1 (index 19) as a normal bit; an all-ones vector emits indices 0..19 in order.
REQ-025 SHALL drive out_index=0 and out_last=0 whenever out_valid=0.

Reset
REQ-026 SHALL, while rst_n=0, immediately force state=IDLE, the pending register to 0, out_valid=0, out_last=0, out_index=0 and zero_seen=0, with in_ready=1.
REQ-027 SHALL abandon a vector that is mid-emission when rst_n is asserted; no further beats of that vector are emitted after reset release.
REQ-028 SHALL accept a new vector in the first cycle after rst_n deasserts.

Structure
REQ-029 SHALL take BIT_WIDTH, IDX_WIDTH and the IDLE/EMIT state encodings from the shared CPU package or header, together with the decoder's width constant.
REQ-030 SHALL use one combinational sub-module, priority_encoder, that maps a BIT_WIDTH vector to the lowest-set index plus an any-set flag.
REQ-031 SHALL have no other sub-modules or memories; expected RTL size is 120-250 lines.

Verification
REQ-032 SHALL check reset: with rst_n=0, in_ready=1, out_valid=0 and zero_seen=0; after release, input_bits=1 is accepted -> one beat, out_index=0, out_last=1.
REQ-033 SHALL check multi-bit: input_bits=20'h80005 with out_ready=1 -> beats 0, 2, 19 on consecutive cycles, out_last only on 19, then in_ready=1.
REQ-034 SHALL check backpressure: input_bits=20'h00012 with out_ready held low 3 cycles -> out_index=1 stable for 3 cycles, then 1 and 4 are emitted.
REQ-035 SHALL check zero: input_bits=0 accepted -> zero_seen=1 for one cycle, out_valid never rises, in_ready stays 1.
REQ-036 SHALL check all-ones: 20'hFFFFF -> 20 beats with indices 0..19, out_last on 19.
REQ-037 SHALL check mid-reset: rst_n pulsed low after the second beat of 20'h000F0 -> out_valid drops immediately, no beats 6/7 afterwards, and a next vector 20'h00008 emits index 3.

Source files
------------

// File: rtl/serial_encoder_pkg.sv
// Shared constants for the serial set-bit encoder: vector/index widths,
// the decoder width and the two-state FSM encoding.
package serial_encoder_pkg;

  localparam int SE_BIT_WIDTH = 20;
  localparam int SE_IDX_WIDTH = 5;

  // Width of the vector handled by the lowest-set-bit decoder.
  localparam int SE_DEC_WIDTH = SE_BIT_WIDTH;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

endpackage

// File: rtl/serial_encoder_priority_encoder.sv
// Combinational lowest-set-bit encoder: returns the index of the least
// significant set bit of vec_i and a flag telling whether any bit is set.
module priority_encoder #(
  parameter int W  = 20,
  parameter int IW = 5
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_o = '0;
    any_o = |vec_i;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/serial_encoder.sv
// Serial encoder: accepts a bit vector and emits the index of each set bit,
// LSB first, one beat per out_valid/out_ready handshake.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | in_ready=1, waiting for a vector; an all-zero vector only
//         | produces a zero_seen pulse
// ST_EMIT | pending register non-zero, presenting its lowest set bit
module serial_encoder
  import serial_encoder_pkg::*;
#(
  parameter int BIT_WIDTH = SE_BIT_WIDTH,
  parameter int IDX_WIDTH = SE_IDX_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [BIT_WIDTH-1:0] input_bits,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [IDX_WIDTH-1:0] out_index,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 zero_seen
);

  logic [0:0]           state_q, state_d;
  logic [BIT_WIDTH-1:0] pend_q, pend_d;
  logic                 zero_q, zero_d;

  logic [IDX_WIDTH-1:0] enc_idx;
  logic                 enc_any;
  logic [BIT_WIDTH-1:0] pend_rest;
  logic                 emitting;
  logic                 last_beat;

  priority_encoder #(
    .W  (BIT_WIDTH),
    .IW (IDX_WIDTH)
  ) u_prio (
    .vec_i (pend_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // Pending vector with its lowest set bit removed; zero means one bit left.
  always_comb begin
    emitting  = (state_q == ST_EMIT);
    pend_rest = pend_q & (pend_q - BIT_WIDTH'(1));
    last_beat = emitting && enc_any && (pend_rest == '0);
  end

  // Outputs are decoded from state so reset clears them without a clock.
  always_comb begin
    in_ready  = ~emitting;
    out_valid = emitting;
    out_index = emitting ? enc_idx : '0;
    out_last  = last_beat;
    zero_seen = zero_q;
  end

  // Next-state logic: capture in IDLE, peel one bit per accepted beat in EMIT.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          pend_d = input_bits;
          if (|input_bits) state_d = ST_EMIT;
          else             zero_d  = 1'b1;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          pend_d = pend_rest;
          if (last_beat) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any vector in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_serial_encoder.sv
// Testbench for serial_encoder: directed scenarios plus randomized vectors
// checked against a queue of expected indices built from the vector bits.
module tb_serial_encoder;

  localparam int BW = 20;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] input_bits = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] out_index;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic          zero_seen;

  int n_cmp = 0;
  int n_err = 0;

  serial_encoder #(.BIT_WIDTH(BW), .IDX_WIDTH(IW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .input_bits (input_bits),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_index  (out_index),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .zero_seen  (zero_seen)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Presents one vector for a single cycle; returns at the negedge after
  // the accepting edge, when the first beat (if any) is visible.
  task automatic send(input logic [BW-1:0] v);
    input_bits = v;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    input_bits = BW'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (zero_seen !== 1'b0) begin n_err++; $display("FAIL rst_zero_seen: got %b want 0", zero_seen); end
    n_cmp++; if (out_index !== '0) begin n_err++; $display("FAIL rst_out_index: got %0d want 0", out_index); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL rst_out_last: got %b want 0", out_last); end
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(BW'(1));
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rst1_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_index !== 5'd0) begin n_err++; $display("FAIL rst1_index: got %0d want 0", out_index); end
    n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL rst1_last: got %b want 1", out_last); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst1_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst1_done_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst1_done_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_multi();
    int exp_idx[3];
    logic [IW-1:0] e;
    exp_idx[0] = 0; exp_idx[1] = 2; exp_idx[2] = 19;
    out_ready  = 1'b1;
    input_bits = 20'h80005;
    in_valid   = 1'b1;
    @(negedge clk);
    for (int j = 0; j < 3; j++) begin
      e = IW'(exp_idx[j]);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL multi_valid[%0d]: got %b want 1", j, out_valid); end
      n_cmp++; if (out_index !== e) begin n_err++; $display("FAIL multi_index[%0d]: got %0d want %0d", j, out_index, e); end
      n_cmp++; if (out_last !== (j == 2)) begin n_err++; $display("FAIL multi_last[%0d]: got %b want %b", j, out_last, (j == 2)); end
      if (j < 2) begin
        in_valid   = 1'b1;
        input_bits = 20'hABCDE;
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL multi_end_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL multi_end_ready: got %b want 1", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL multi_no_overlap: got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(20'h00012);
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_valid[%0d]: got %b want 1", c, out_valid); end
      n_cmp++; if (out_index !== 5'd1) begin n_err++; $display("FAIL bp_index[%0d]: got %0d want 1", c, out_index); end
      n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL bp_last[%0d]: got %b want 0", c, out_last); end
      if (c == 2) out_ready = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (out_index !== 5'd4) begin n_err++; $display("FAIL bp_second_index: got %0d want 4", out_index); end
    n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL bp_second_last: got %b want 1", out_last); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    send('0);
    n_cmp++; if (zero_seen !== 1'b1) begin n_err++; $display("FAIL zero_pulse: got %b want 1", zero_seen); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready: got %b want 1", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (zero_seen !== 1'b0) begin n_err++; $display("FAIL zero_pulse_end[%0d]: got %b want 0", c, zero_seen); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid_after[%0d]: got %b want 0", c, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL zero_ready_after[%0d]: got %b want 1", c, in_ready); end
    end
  endtask

  task automatic test_all_ones();
    logic [IW-1:0] e;
    out_ready = 1'b1;
    send(20'hFFFFF);
    for (int i = 0; i < BW; i++) begin
      e = IW'(i);
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL ones_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_index !== e) begin n_err++; $display("FAIL ones_index[%0d]: got %0d want %0d", i, out_index, e); end
      n_cmp++; if (out_last !== (i == BW - 1)) begin n_err++; $display("FAIL ones_last[%0d]: got %b want %b", i, out_last, (i == BW - 1)); end
      @(negedge clk);
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL ones_end_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    send(20'h000F0);
    n_cmp++; if (out_index !== 5'd4) begin n_err++; $display("FAIL mr_beat0: got %0d want 4", out_index); end
    @(negedge clk);
    n_cmp++; if (out_index !== 5'd5) begin n_err++; $display("FAIL mr_beat1: got %0d want 5", out_index); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_valid_drop: got %b want 0", out_valid); end
    n_cmp++; if (out_index !== '0) begin n_err++; $display("FAIL mr_index_clr: got %0d want 0", out_index); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mr_ready: got %b want 1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_no_beat[%0d]: got valid %b index %0d want valid 0", c, out_valid, out_index); end
    end
    send(20'h00008);
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mr_next_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_index !== 5'd3) begin n_err++; $display("FAIL mr_next_index: got %0d want 3", out_index); end
    n_cmp++; if (out_last !== 1'b1) begin n_err++; $display("FAIL mr_next_last: got %b want 1", out_last); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mr_next_done: got %b want 0", out_valid); end
  endtask

  task automatic test_random();
    logic [BW-1:0] v;
    logic [IW-1:0] e;
    int q[$];
    int budget;
    logic rdy;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 3))
        0: v = '0;
        1: begin v = '0; v[$urandom_range(0, BW - 1)] = 1'b1; end
        default: v = BW'($urandom);
      endcase
      q.delete();
      for (int b = 0; b < BW; b++) if (v[b]) q.push_back(b);
      out_ready = 1'($urandom);
      send(v);
      n_cmp++; if (zero_seen !== (v == '0)) begin n_err++; $display("FAIL rnd_zero[%0d]: got %b want %b v=%h", n, zero_seen, (v == '0), v); end
      budget = 0;
      while (q.size() > 0 && budget < 200) begin
        e = IW'(q[0]);
        n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rnd_valid[%0d]: got %b want 1 v=%h", n, out_valid, v); end
        n_cmp++; if (out_index !== e) begin n_err++; $display("FAIL rnd_index[%0d]: got %0d want %0d v=%h", n, out_index, e, v); end
        n_cmp++; if (out_last !== (q.size() == 1)) begin n_err++; $display("FAIL rnd_last[%0d]: got %b want %b v=%h", n, out_last, (q.size() == 1), v); end
        rdy = 1'($urandom);
        out_ready = rdy;
        @(negedge clk);
        if (rdy) void'(q.pop_front());
        budget++;
      end
      n_cmp++; if (q.size() != 0) begin n_err++; $display("FAIL rnd_budget[%0d]: got %0d beats left want 0", n, q.size()); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rnd_end_valid[%0d]: got %b want 0", n, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rnd_end_ready[%0d]: got %b want 1", n, in_ready); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_multi();
    test_backpressure();
    test_zero();
    test_all_ones();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
